// File: rtl/fp16_add_arbiter_if.sv
// Requester/adder bundle for the shared FP16 adder arbiter.
// The arbiter uses the slave view; the requesters plus adder side use master.
interface fp16_add_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3
);
    logic                               hold;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [16*NUM_REQ-1:0]              req_a;
    logic [16*NUM_REQ-1:0]              req_b;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [15:0]                        add_fp1_out;
    logic [15:0]                        add_fp2_out;
    logic                               add_valid_out;
    logic [15:0]                        add_result_in;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [15:0]                        rsp_data;
    logic [$clog2(ADD_LATENCY+3)-1:0]   inflight;
    logic                               busy;

    modport slave (
        input  hold, req_valid, req_a, req_b, add_result_in,
        output req_ready, add_fp1_out, add_fp2_out, add_valid_out,
        output rsp_valid, rsp_data, inflight, busy
    );

    modport master (
        output hold, req_valid, req_a, req_b, add_result_in,
        input  req_ready, add_fp1_out, add_fp2_out, add_valid_out,
        input  rsp_valid, rsp_data, inflight, busy
    );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin sharing of one feed-forward FP16 adder among NUM_REQ requesters.
// A {valid,id} tag pipeline tracks each op so its result returns to its originator.
module fp16_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3
) (
    input logic               clk,
    input logic               nRST,
    fp16_add_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ADD_LATENCY + 3);

    logic [IW-1:0]                  ptr_q, ptr_d;
    logic [IW:0]                    cand;
    logic [NUM_REQ-1:0]             gnt;
    logic [IW-1:0]                  gnt_id;
    logic                           gnt_vld;
    logic [15:0]                    sel_a, sel_b;
    logic [15:0]                    fp1_q, fp2_q;
    logic                           issue_q;
    logic [IW-1:0]                  iss_id_q;
    logic [ADD_LATENCY-1:0]         vld_pipe_q;
    logic [ADD_LATENCY-1:0][IW-1:0] id_pipe_q;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [15:0]                    rsp_data_q;
    logic [CW-1:0]                  inflight_q, inflight_d;
    logic                           busy_q;

    // Scan lanes starting at ptr; the outer offset loop gives priority order.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        cand    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(j);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_vld && !bus.hold && bus.req_valid[k] && cand == (IW+1)'(k)) begin
                    gnt_vld = 1'b1;
                    gnt[k]  = 1'b1;
                    gnt_id  = IW'(k);
                    sel_a   = bus.req_a[k*16 +: 16];
                    sel_b   = bus.req_b[k*16 +: 16];
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        rsp_valid_d = '0;
        for (int k = 0; k < NUM_REQ; k++)
            rsp_valid_d[k] = vld_pipe_q[ADD_LATENCY-1] && (id_pipe_q[ADD_LATENCY-1] == IW'(k));
        // Accept and retire in the same cycle cancel out.
        inflight_d = inflight_q + CW'(gnt_vld) - CW'(|rsp_valid_q);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q       <= '0;
            fp1_q       <= '0;
            fp2_q       <= '0;
            issue_q     <= 1'b0;
            iss_id_q    <= '0;
            vld_pipe_q  <= '0;
            id_pipe_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            issue_q  <= gnt_vld;
            iss_id_q <= gnt_id;
            if (gnt_vld) begin
                fp1_q <= sel_a;
                fp2_q <= sel_b;
            end
            // Tag pipe never stalls; its last stage lines up with add_result_in.
            vld_pipe_q[0] <= issue_q;
            id_pipe_q[0]  <= iss_id_q;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                id_pipe_q[s]  <= id_pipe_q[s-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (vld_pipe_q[ADD_LATENCY-1]) rsp_data_q <= bus.add_result_in;
            inflight_q <= inflight_d;
            busy_q     <= (inflight_d != '0);
        end
    end

    assign bus.req_ready     = gnt;
    assign bus.add_fp1_out   = fp1_q;
    assign bus.add_fp2_out   = fp2_q;
    assign bus.add_valid_out = issue_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.inflight      = inflight_q;
    assign bus.busy          = busy_q;
endmodule
